fifo_unpack: RTL and testbench

Pixel unpacker on the read side of the 72-bit line FIFO. Pops first-word-fall-through words, each holding three 24-bit RGB pixels, and emits one pixel per cycle on a valid/ready stream. Tags each pixel with start/end-of-line and start/end-of-frame flags. Lines start word-aligned in the FIFO, so unused slots in the last word of each line are discarded.

---
 rtl/fifo_unpack_if.sv | 33 +++
 rtl/fifo_unpack.sv | 163 ++++++++++++++++
 tb/tb_fifo_unpack.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_unpack_if.sv
// Bundle of the unpacker's frame control, FIFO read side and pixel stream.
// The master modport is the unpacker's view; slave is its environment.
interface fifo_unpack_if #(
  parameter int WIDTH_BITS = 12
);
  // frame control
  logic                  enable;
  logic [WIDTH_BITS-1:0] hsize;
  logic [WIDTH_BITS-1:0] vsize;
  logic                  busy;
  // FWFT FIFO read side
  logic [71:0]           fifo_rddata;
  logic                  fifo_empty;
  logic                  fifo_rden;
  // pixel stream
  logic [23:0]           out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sol;
  logic                  out_eol;
  logic                  out_sof;
  logic                  out_eof;

  modport master (
    input  enable, hsize, vsize, fifo_rddata, fifo_empty, out_ready,
    output busy, fifo_rden, out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );

  modport slave (
    output enable, hsize, vsize, fifo_rddata, fifo_empty, out_ready,
    input  busy, fifo_rden, out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );
endinterface

// File: rtl/fifo_unpack.sv
// Pixel unpacker: pops 72-bit FWFT words holding three 24-bit pixels and
// emits one pixel per cycle with line/frame markers. Each line starts on a
// fresh word, so slots past the end of a line are dropped.
module fifo_unpack #(
  parameter int WIDTH_BITS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_unpack_if.master bus
);

  localparam int WL = 2 * WIDTH_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [WIDTH_BITS-1:0] hsize_q;
  logic [WIDTH_BITS-1:0] vsize_q;
  logic [WIDTH_BITS-1:0] x_q;
  logic [WIDTH_BITS-1:0] y_q;
  logic [WL-1:0]         words_left_q;

  logic [71:0]           wbuf_q;
  logic                  wvalid_q;
  logic [1:0]            idx_q;

  logic [23:0]           out_data_q;
  logic                  out_valid_q;
  logic                  sol_q;
  logic                  eol_q;
  logic                  sof_q;
  logic                  eof_q;

  logic                  start_s;
  logic                  xfer_s;
  logic                  accept_s;
  logic                  last_x_s;
  logic                  last_y_s;
  logic                  drain_s;
  logic                  rden_s;
  logic [23:0]           slot_s;
  logic [WIDTH_BITS+1:0] wpl_s;
  logic [WL-1:0]         frame_words_s;

  // Handshake decode, word drain and pop decisions, slot selection
  always_comb begin
    start_s  = (state_q == IDLE) && bus.enable &&
               (bus.hsize != {WIDTH_BITS{1'b0}}) && (bus.vsize != {WIDTH_BITS{1'b0}});
    // words per line = ceil(hsize/3), widened so hsize+2 cannot wrap
    wpl_s         = ({2'b00, bus.hsize} + (WIDTH_BITS+2)'(2)) / (WIDTH_BITS+2)'(3);
    frame_words_s = WL'(wpl_s) * WL'(bus.vsize);
    xfer_s   = wvalid_q && (!out_valid_q || bus.out_ready);
    accept_s = out_valid_q && bus.out_ready;
    last_x_s = (x_q == hsize_q - WIDTH_BITS'(1));
    last_y_s = (y_q == vsize_q - WIDTH_BITS'(1));
    // a word is finished after its third slot or at end of line
    drain_s  = xfer_s && ((idx_q == 2'd2) || last_x_s);
    // refill in the same cycle as the drain so the stream has no bubble;
    // words_left stops us reading into the next frame's data
    rden_s   = (state_q == RUN) && !bus.fifo_empty &&
               (words_left_q != {WL{1'b0}}) && (!wvalid_q || drain_s);
    case (idx_q)
      2'd0:    slot_s = wbuf_q[23:0];
      2'd1:    slot_s = wbuf_q[47:24];
      2'd2:    slot_s = wbuf_q[71:48];
      default: slot_s = 24'd0;
    endcase
  end

  assign bus.fifo_rden = rden_s;
  assign bus.busy      = (state_q == RUN);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sol   = sol_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eof   = eof_q;

  // Frame FSM: latch geometry at start, track pixel position and words left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hsize_q      <= {WIDTH_BITS{1'b0}};
      vsize_q      <= {WIDTH_BITS{1'b0}};
      x_q          <= {WIDTH_BITS{1'b0}};
      y_q          <= {WIDTH_BITS{1'b0}};
      words_left_q <= {WL{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q      <= RUN;
            hsize_q      <= bus.hsize;
            vsize_q      <= bus.vsize;
            x_q          <= {WIDTH_BITS{1'b0}};
            y_q          <= {WIDTH_BITS{1'b0}};
            words_left_q <= frame_words_s;
          end
        end
        RUN: begin
          if (rden_s) begin
            words_left_q <= words_left_q - WL'(1);
          end
          if (xfer_s) begin
            if (last_x_s) begin
              x_q <= {WIDTH_BITS{1'b0}};
              y_q <= y_q + WIDTH_BITS'(1);
            end else begin
              x_q <= x_q + WIDTH_BITS'(1);
            end
          end
          if (accept_s && eof_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Word buffer: load on pop, step through slots, release on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_q   <= 72'd0;
      wvalid_q <= 1'b0;
      idx_q    <= 2'd0;
    end else if (rden_s) begin
      wbuf_q   <= bus.fifo_rddata;
      wvalid_q <= 1'b1;
      idx_q    <= 2'd0;
    end else if (drain_s) begin
      wvalid_q <= 1'b0;
      idx_q    <= 2'd0;
    end else if (xfer_s) begin
      idx_q    <= idx_q + 2'd1;
    end
  end

  // Output register: capture pixel and markers, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= 24'd0;
      out_valid_q <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else if (xfer_s) begin
      out_data_q  <= slot_s;
      out_valid_q <= 1'b1;
      sol_q       <= (x_q == {WIDTH_BITS{1'b0}});
      eol_q       <= last_x_s;
      sof_q       <= (x_q == {WIDTH_BITS{1'b0}}) && (y_q == {WIDTH_BITS{1'b0}});
      eof_q       <= last_x_s && last_y_s;
    end else if (accept_s) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Self-checking bench for fifo_unpack: a queue-based FWFT FIFO model and an
// expected-pixel list built from frame geometry (line l, column x -> word
// l*ceil(h/3)+x/3, slot x%3).
module tb_fifo_unpack;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_unpack_if #(.WIDTH_BITS(W)) ifc ();
  fifo_unpack #(.WIDTH_BITS(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int total = 0;
  int bad = 0;

  logic [71:0] fq[$];
  logic [27:0] expq[$];   // {data, sol, eol, sof, eof}
  int cyc = 0, pops = 0, dw_g = -1, dly_cnt = 0;
  int nframes = 1, starts = 0, frame_idx = 0;
  int fh[2], fv[2];
  int sof_cyc = 0, eof_cyc = 0, start_cyc = 0;
  bit full_rate = 0, chk_lat = 0, prev_busy = 0, prev_stall = 0, prev_valid = 0;
  logic [27:0] saved = '0;
  int rh, rv, rm, rdw, rdc, rex;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic update_fifo();
    ifc.fifo_empty  = (fq.size() == 0) || (pops == dw_g && dly_cnt > 0);
    ifc.fifo_rddata = (fq.size() != 0) ? fq[0] : 72'd0;
  endtask

  // one clock: sample just before the edge, advance, then update the FIFO model
  task automatic step();
    logic [27:0] cur, e;
    bit pop_s, acc, acc_eof;
    #1;
    cur = {ifc.out_data, ifc.out_sol, ifc.out_eol, ifc.out_sof, ifc.out_eof};
    pop_s = ifc.fifo_rden;
    acc = ifc.out_valid && ifc.out_ready;
    acc_eof = 0;
    if (pop_s) chk("rden_when_empty", {31'd0, ifc.fifo_empty}, 32'd0);
    if (prev_stall) begin
      chk("stall_valid", {31'd0, ifc.out_valid}, 32'd1);
      chk("stall_hold", {4'd0, cur}, {4'd0, saved});
    end
    if (ifc.out_valid && !prev_valid && chk_lat && expq.size() > 0 && expq[0][1])
      chk("first_valid_latency", cyc - start_cyc, 32'd2);
    if (acc) begin
      if (expq.size() == 0) begin
        chk("extra_pixel", expq.size(), 32'd1);
      end else begin
        e = expq.pop_front();
        chk("pixel", {4'd0, cur}, {4'd0, e});
        if (e[1]) begin
          if (frame_idx > 0 && full_rate)
            chk("sof_gap_le3", ((cyc - eof_cyc - 1) <= 3) ? 32'd1 : 32'd0, 32'd1);
          sof_cyc = cyc;
        end
        if (e[0]) begin
          if (full_rate) chk("full_rate", cyc - sof_cyc, fh[frame_idx] * fv[frame_idx] - 1);
          eof_cyc = cyc;
          acc_eof = 1;
        end
      end
    end
    prev_stall = ifc.out_valid && !ifc.out_ready;
    prev_valid = ifc.out_valid;
    saved = cur;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    if (acc_eof) begin
      chk("busy_after_eof", {31'd0, ifc.busy}, 32'd0);
      frame_idx++;
      if (frame_idx < nframes) begin
        ifc.hsize = W'(fh[frame_idx]);
        ifc.vsize = W'(fv[frame_idx]);
      end
    end
    if (ifc.busy && !prev_busy) begin
      starts++;
      start_cyc = cyc;
      if (starts >= nframes) ifc.enable = 1'b0;
    end
    prev_busy = ifc.busy;
    if (dly_cnt > 0 && pops == dw_g) dly_cnt--;
    update_fifo();
  endtask

  task automatic run_frames(input int nf, input int h0, input int v0, input int h1, input int v1,
                            input int rmode, input int dw, input int dc, input int extra);
    int wpl, base, nw, k, budget, widx;
    logic [71:0] w;
    logic [23:0] px;
    nframes = nf; fh[0] = h0; fv[0] = v0; fh[1] = h1; fv[1] = v1;
    frame_idx = 0; starts = 0; pops = 0; dw_g = dw; dly_cnt = dc;
    full_rate = (rmode == 0) && (dc == 0);
    chk_lat = !(dw == 0 && dc > 0);
    fq.delete(); expq.delete();
    for (int f = 0; f < nf; f++) begin
      wpl = (fh[f] + 2) / 3;
      base = fq.size();
      for (int i = 0; i < wpl * fv[f]; i++) begin
        w = {8'($urandom), $urandom, $urandom};
        fq.push_back(w);
      end
      for (int y = 0; y < fv[f]; y++) begin
        for (int x = 0; x < fh[f]; x++) begin
          widx = base + y * wpl + x / 3;
          w = fq[widx];
          px = w[(x % 3) * 24 +: 24];
          expq.push_back({px, x == 0, x == fh[f] - 1, x == 0 && y == 0,
                          x == fh[f] - 1 && y == fv[f] - 1});
        end
      end
    end
    nw = fq.size();
    for (int i = 0; i < extra; i++) begin
      w = {8'($urandom), $urandom, $urandom};
      fq.push_back(w);
    end
    ifc.hsize = W'(h0);
    ifc.vsize = W'(v0);
    ifc.enable = 1'b1;
    update_fifo();
    budget = 4 * (h0 * v0 + h1 * v1) + 100 + 10 * dc;
    k = 0;
    while ((expq.size() > 0 || ifc.busy || k == 0) && k < budget) begin
      case (rmode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = (k % 3 == 0);
        default: ifc.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      step();
      k++;
    end
    if (k >= budget) chk("timeout", expq.size(), 32'd0);
    chk("pixels_left", expq.size(), 32'd0);
    chk("pop_count", pops, nw);
    ifc.out_ready = 1'b1;
    step();
    step();
    chk("no_overfetch", pops, nw);
    chk("idle_after_frame", {31'd0, ifc.busy}, 32'd0);
    ifc.enable = 1'b0;
    dw_g = -1;
    dly_cnt = 0;
  endtask

  initial begin
    ifc.enable = 1'b0;
    ifc.hsize = '0;
    ifc.vsize = '0;
    ifc.out_ready = 1'b0;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_rddata = '0;
    #1;
    chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("rst_rden", {31'd0, ifc.fifo_rden}, 32'd0);
    chk("rst_data_flags", {4'd0, ifc.out_data, ifc.out_sol, ifc.out_eol, ifc.out_sof, ifc.out_eof}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // two lines of six pixels at full rate
    run_frames(1, 6, 2, 0, 0, 0, -1, 0, 0);
    // partial last word: two slots dropped
    run_frames(1, 4, 1, 0, 0, 0, -1, 0, 1);
    // backpressure 1,0,0 pattern
    run_frames(1, 3, 1, 0, 0, 1, -1, 0, 1);
    // second word arrives five cycles late
    run_frames(1, 9, 1, 0, 0, 0, 1, 5, 0);
    // back-to-back frames, hsize re-sampled 6 then 3
    run_frames(2, 6, 1, 3, 1, 0, -1, 0, 0);
    // one pixel per line
    run_frames(1, 1, 3, 0, 0, 0, -1, 0, 1);

    // zero geometry never starts
    fq.delete();
    fq.push_back(72'h1);
    fq.push_back(72'h2);
    pops = 0;
    ifc.hsize = '0;
    ifc.vsize = W'(2);
    ifc.enable = 1'b1;
    update_fifo();
    for (int i = 0; i < 5; i++) step();
    chk("hsize0_busy", {31'd0, ifc.busy}, 32'd0);
    ifc.hsize = W'(3);
    ifc.vsize = '0;
    for (int i = 0; i < 5; i++) step();
    chk("vsize0_busy", {31'd0, ifc.busy}, 32'd0);
    chk("zero_geom_pops", pops, 32'd0);
    ifc.enable = 1'b0;

    // random frames with random ready and FIFO underflow
    for (int i = 0; i < 8; i++) begin
      rh = $urandom_range(1, 10);
      rv = $urandom_range(1, 3);
      rm = 2;
      rdw = $urandom_range(0, 2);
      rdc = $urandom_range(0, 4);
      rex = $urandom_range(0, 2);
      run_frames(1, rh, rv, 0, 0, rm, rdw, rdc, rex);
    end

    // widest legal line
    run_frames(1, 4095, 1, 0, 0, 0, -1, 0, 1);

    // reset in the middle of a frame
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back({8'($urandom), $urandom, $urandom});
    expq.delete();
    pops = 0;
    nframes = 1; starts = 0; chk_lat = 0; full_rate = 0;
    ifc.hsize = W'(9);
    ifc.vsize = W'(2);
    ifc.out_ready = 1'b0;
    ifc.enable = 1'b1;
    update_fifo();
    for (int i = 0; i < 6; i++) step();
    chk("pre_reset_busy", {31'd0, ifc.busy}, 32'd1);
    chk("pre_reset_valid", {31'd0, ifc.out_valid}, 32'd1);
    ifc.enable = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("midrst_rden", {31'd0, ifc.fifo_rden}, 32'd0);
    prev_stall = 0; prev_valid = 0; prev_busy = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pops = 0;
    for (int i = 0; i < 4; i++) step();
    chk("post_reset_idle", {31'd0, ifc.busy}, 32'd0);
    chk("post_reset_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("post_reset_pops", pops, 32'd0);
    run_frames(1, 5, 2, 0, 0, 0, -1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
